// File: rtl/axi_read_prefetch_pkg.sv
// Shared types and constants for the AXI read prefetch scheduler.
package axi_read_prefetch_pkg;

    typedef enum logic [2:0] {
        Idle      = 3'd0,
        WaitSpace = 3'd1,
        Issue     = 3'd2,
        WaitDone  = 3'd3,
        Finish    = 3'd4
    } PrefetchState_t;

    localparam int unsigned BYTES_PER_WORD = 32'd4;

    function automatic logic [31:0] min_len(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_read_prefetch_sync_fifo.sv
// Synchronous first-word fall-through FIFO; a pop frees a slot for a push in the same cycle.
module sync_fifo
    import axi_read_prefetch_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DATA_W-1:0]            din,
    input  logic                         pop,
    output logic [DATA_W-1:0]            dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    // Accept/ignore decisions: push into a full FIFO only succeeds alongside a pop.
    always_comb begin
        pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
        push_ok_s = push && ((count_r != CNT_W'(DEPTH)) || pop_ok_s);
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            if (push_ok_s && !pop_ok_s) begin
                count_r <= count_r + CNT_W'(1'b1);
            end else if (!push_ok_s && pop_ok_s) begin
                count_r <= count_r - CNT_W'(1'b1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/axi_read_prefetch.sv
// Chunked command scheduler for the single-beat AXI read engine with a FWFT output buffer.
// Optional WAIT_DONE watchdog and timeout_err port enabled by AXI_READ_PREFETCH_TIMEOUT_EN.
module axi_read_prefetch #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int DEPTH          = 16,
    parameter int CHUNK_WORDS    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       total_words,
    output logic              busy,
    output logic [ADDR_W-1:0] rd_addr_out,
    output logic [31:0]       rd_len_out,
    output logic              rd_en_out,
    input  logic [DATA_W-1:0] rd_data_in,
    input  logic              rd_dval_in,
    input  logic              rd_done_in,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              xfer_done,
    output logic              overflow
`ifdef AXI_READ_PREFETCH_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    import axi_read_prefetch_pkg::*;

    localparam int CNT_W = $clog2(DEPTH+1);

    if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < CHUNK_WORDS) || (CHUNK_WORDS < 1) ||
        (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_cfg
        $error("axi_read_prefetch: unsupported parameter combination");
    end

    PrefetchState_t    state_r;
    logic [31:0]       remaining_r;
    logic [ADDR_W-1:0] next_addr_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic [31:0]       rd_len_r;
    logic              rd_en_r;
    logic              busy_r;
    logic              xfer_done_r;
    logic              overflow_r;
    logic [31:0]       chunk_len_s;
    logic              space_ok_s;
    logic              pop_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
`ifdef AXI_READ_PREFETCH_TIMEOUT_EN
    logic [15:0]       wd_cnt_r;
    logic              timeout_err_r;
`endif

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_dval_in),
        .din   (rd_data_in),
        .pop   (pop_s),
        .dout  (m_data),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Next chunk size and whether the buffer can absorb all of it without stalling the engine.
    always_comb begin
        chunk_len_s = min_len(remaining_r, 32'(CHUNK_WORDS));
        space_ok_s  = ((32'(DEPTH) - 32'(fifo_count_s)) >= chunk_len_s);
        pop_s       = !fifo_empty_s && m_ready;
    end

    // Transfer sequencing; rd_en_r is raised on entry to Issue so it is high for that cycle only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= Idle;
            remaining_r <= 32'd0;
            next_addr_r <= {ADDR_W{1'b0}};
            rd_addr_r   <= {ADDR_W{1'b0}};
            rd_len_r    <= 32'd0;
            rd_en_r     <= 1'b0;
            busy_r      <= 1'b0;
            xfer_done_r <= 1'b0;
`ifdef AXI_READ_PREFETCH_TIMEOUT_EN
            wd_cnt_r      <= 16'd0;
            timeout_err_r <= 1'b0;
`endif
        end else begin
            rd_en_r     <= 1'b0;
            xfer_done_r <= 1'b0;
            case (state_r)
                Idle: begin
                    if (start) begin
                        remaining_r <= total_words;
                        next_addr_r <= base_addr;
                        busy_r      <= 1'b1;
                        state_r     <= (total_words == 32'd0) ? Finish : WaitSpace;
                    end
                end
                WaitSpace: begin
                    if (space_ok_s) begin
                        rd_en_r   <= 1'b1;
                        rd_addr_r <= next_addr_r;
                        rd_len_r  <= chunk_len_s;
                        state_r   <= Issue;
                    end
                end
                Issue: begin
                    remaining_r <= remaining_r - rd_len_r;
                    next_addr_r <= next_addr_r + ADDR_W'(rd_len_r * BYTES_PER_WORD);
                    state_r     <= WaitDone;
`ifdef AXI_READ_PREFETCH_TIMEOUT_EN
                    wd_cnt_r    <= 16'd0;
`endif
                end
                WaitDone: begin
                    if (rd_done_in) begin
                        state_r <= (remaining_r != 32'd0) ? WaitSpace : Finish;
`ifdef AXI_READ_PREFETCH_TIMEOUT_EN
                    end else if (wd_cnt_r == 16'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err_r <= 1'b1;
                        busy_r        <= 1'b0;
                        state_r       <= Idle;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + 16'd1;
`endif
                    end
                end
                Finish: begin
                    if (fifo_empty_s && !rd_dval_in) begin
                        xfer_done_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= Idle;
                    end
                end
                default: begin
                    state_r <= Idle;
                end
            endcase
        end
    end

    // Sticky drop flag: a word arrived with the buffer full and nothing leaving.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (rd_dval_in && fifo_full_s && !pop_s) begin
            overflow_r <= 1'b1;
        end
    end

    assign busy        = busy_r;
    assign rd_addr_out = rd_addr_r;
    assign rd_len_out  = rd_len_r;
    assign rd_en_out   = rd_en_r;
    assign xfer_done   = xfer_done_r;
    assign overflow    = overflow_r;
    assign m_valid     = !fifo_empty_s;
`ifdef AXI_READ_PREFETCH_TIMEOUT_EN
    assign timeout_err = timeout_err_r;
`endif

endmodule

// File: doc/axi_read_prefetch.md
Name: axi_read_prefetch

Overview:
Upstream scheduler and downstream buffer for the single-beat AXI read engine.
- Splits a (base address, word count) transfer into chunks and issues one chunk at a time on the engine's addr/len/en command inputs.
- Captures the engine's dval words into an internal FIFO.
- Presents the words as a valid/ready stream to the compute datapath.
- Issues a chunk only when the FIFO has room for the whole chunk, so the engine never stalls on a full buffer.

Parameters:
DATA_W, 32, data word width (must match the engine's read data width)
ADDR_W, 32, byte address width
DEPTH, 16, FIFO depth in words (power of two, >= CHUNK_WORDS)
CHUNK_WORDS, 4, maximum words per command issued to the engine
TIMEOUT_CYCLES, 1024, watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request to begin a transfer
base_addr  in  ADDR_W  byte address of the first word, sampled on start
total_words  in  32  words to fetch, sampled on start
busy  out  1  transfer in progress
rd_addr_out  out  ADDR_W  chunk address to the engine
rd_len_out  out  32  chunk length in words to the engine (never 0)
rd_en_out  out  1  one-cycle chunk issue pulse to the engine
rd_data_in  in  DATA_W  engine read data
rd_dval_in  in  1  engine data-valid strobe
rd_done_in  in  1  engine chunk-complete pulse
m_data  out  DATA_W  stream data, first-word fall-through
m_valid  out  1  FIFO not empty
m_ready  in  1  consumer accepts m_data
xfer_done  out  1  one-cycle pulse when the transfer is fully fetched and drained
overflow  out  1  sticky flag: a word arrived while the FIFO was full

Behaviour:
- Reset (clk edge with rst=1):
  - State returns to IDLE; FIFO is emptied.
  - busy, rd_en_out, xfer_done, overflow, m_valid all 0; rd_addr_out = 0; rd_len_out = 0.
  - Reset mid-transfer abandons the transfer. The engine has its own reset; the system resets both together.
- Registers:
  - remaining: words not yet issued, 32-bit.
  - next_addr: address of the next chunk, ADDR_W bits, wraps modulo 2^ADDR_W.
  - fifo_count: $clog2(DEPTH+1) bits.
- Chunk length: clen = min(CHUNK_WORDS, remaining).
- State machine:
  - IDLE: on start, load remaining = total_words and next_addr = base_addr, and set busy = 1.
    - If total_words == 0, go to FINISH.
    - Otherwise go to WAIT_SPACE.
    - start while busy is ignored.
  - WAIT_SPACE: when (DEPTH - fifo_count) >= clen, go to ISSUE.
  - ISSUE (exactly one cycle):
    - rd_en_out = 1; rd_addr_out = next_addr; rd_len_out = clen.
    - Update remaining -= clen and next_addr += clen*4.
    - Go to WAIT_DONE.
  - WAIT_DONE: on rd_done_in, go to WAIT_SPACE if remaining != 0, else FINISH.
    - The earliest next issue is 2 cycles after the done pulse, so the engine is back in its idle state.
  - FINISH: when fifo_count == 0 and no push is occurring this cycle:
    - Pulse xfer_done for 1 cycle.
    - Clear busy the same cycle.
    - Go to IDLE.
- rd_addr_out and rd_len_out are registered and hold their value after ISSUE.
- FIFO:
  - push on rd_dval_in; pop on m_valid && m_ready. m_data is the head word, valid in the same cycle m_valid rises.
  - Push and pop in the same cycle: both take effect, count unchanged. This also applies when full: the pop frees a slot and the push is accepted.
  - Push when full without a pop: word dropped, overflow set (sticky until rst).
  - Pop when empty: ignored.
  - Pointers wrap modulo DEPTH.
- rd_dval_in outside WAIT_DONE is still pushed (defensive), not flagged.
- Latency: rd_dval_in at cycle t gives m_valid at t+1.

Optional Feature:
- Macro: AXI_READ_PREFETCH_TIMEOUT_EN.
- Defined:
  - Adds output timeout_err (1 bit, sticky until rst).
  - A 16-bit cycle counter runs in WAIT_DONE and clears on entry to WAIT_DONE.
  - When the counter reaches TIMEOUT_CYCLES without rd_done_in, set timeout_err, drop busy, and go to IDLE. FIFO contents remain readable.
- Not defined: no port and no counter; WAIT_DONE waits indefinitely.

Decomposition:
- Package axi_read_prefetch_pkg: PrefetchState_t enum {Idle, WaitSpace, Issue, WaitDone, Finish}, and constant BYTES_PER_WORD = 4.
- One sub-module: sync_fifo, parameterised on DATA_W and DEPTH.
  - Ports: clk, rst, push, din, pop, dout, count, full, empty.
  - Same clk/rst rules as the parent.

Test Plan:
- total_words=10, base=0x1000, m_ready=1 → commands (0x1000,4), (0x1010,4), (0x1020,2). 10 words stream out in order; xfer_done once; busy low afterwards.
- total_words=0 → no rd_en_out; xfer_done pulses 2 cycles after start.
- m_ready=0, total_words=32, DEPTH=16 → exactly 4 chunks issued, then stall in WAIT_SPACE. Raise m_ready → remaining 4 chunks issued; overflow stays 0.
- FIFO full with simultaneous forced push and pop → count stays 16, no overflow. Push only while full → overflow=1, word dropped.
- base=0xFFFFFFF8, total_words=8 → second chunk address wraps to 0x00000008.
- rst asserted in WAIT_DONE → next cycle busy=0, m_valid=0, fifo empty; a new start works normally. With the macro defined, withholding rd_done_in for 1024 cycles → timeout_err=1.
